// File: rtl/div_sequencer_if.sv
// Start/done handshake and result bus between a requester and the divider.
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, is_signed, dividend, divisor,
        input  ready, busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output ready, busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_sequencer.sv
// Iterative restoring divider: one shift/trial-subtract per cycle, MSB first,
// on operand magnitudes; signs are reapplied when the result is registered.
module div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clock,
    input  logic           reset,
    div_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] partRem_q, partRem_d;
    logic [WIDTH-1:0] divisorMag_q, divisorMag_d;
    logic [WIDTH-1:0] quotOut_q, quotOut_d;
    logic [WIDTH-1:0] remOut_q, remOut_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic qNeg_q, qNeg_d;
    logic rNeg_q, rNeg_d;
    logic ovfPend_q, ovfPend_d;
    logic divZero_q, divZero_d;
    logic ovf_q, ovf_d;

    logic             accept;
    logic             lastIter;
    logic             dividendSign;
    logic             divisorSign;
    logic [WIDTH-1:0] dividendMag;
    logic [WIDTH-1:0] divisorMagIn;
    logic [WIDTH:0]   shiftRem;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quotNext;
    logic [WIDTH-1:0] remNext;

    assign accept   = (state_q == IDLE) && bus.start;
    assign lastIter = (count_q == '0);

    // Operand magnitudes and the single shared shift/trial-subtract step.
    // The shifted remainder keeps WIDTH+1 bits so a divisor above 2^(WIDTH-1)
    // never loses the bit shifted out of the partial remainder.
    always_comb begin
        dividendSign = bus.is_signed & bus.dividend[WIDTH-1];
        divisorSign  = bus.is_signed & bus.divisor[WIDTH-1];
        dividendMag  = dividendSign ? (~bus.dividend + 1'b1) : bus.dividend;
        divisorMagIn = divisorSign  ? (~bus.divisor + 1'b1)  : bus.divisor;
        shiftRem     = {partRem_q, quot_q[WIDTH-1]};
        trial        = shiftRem - {1'b0, divisorMag_q};
        quotNext     = {quot_q[WIDTH-2:0], 1'b0};
        remNext      = shiftRem[WIDTH-1:0];
        if (!trial[WIDTH]) begin
            remNext  = trial[WIDTH-1:0];
            quotNext = {quot_q[WIDTH-2:0], 1'b1};
        end
    end

    // Control FSM next state plus the handshake outputs decoded from state.
    always_comb begin
        state_d  = state_q;
        bus.ready = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state_q)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) begin
                    state_d = (bus.divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (lastIter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: capture on accept, iterate in RUN, register results on DONE entry.
    always_comb begin
        quot_d       = quot_q;
        partRem_d    = partRem_q;
        divisorMag_d = divisorMag_q;
        quotOut_d    = quotOut_q;
        remOut_d     = remOut_q;
        count_d      = count_q;
        qNeg_d       = qNeg_q;
        rNeg_d       = rNeg_q;
        ovfPend_d    = ovfPend_q;
        divZero_d    = divZero_q;
        ovf_d        = ovf_q;
        if (accept) begin
            if (bus.divisor == '0) begin
                quotOut_d = '1;
                remOut_d  = bus.dividend;
                divZero_d = 1'b1;
                ovf_d     = 1'b0;
            end else begin
                quot_d       = dividendMag;
                divisorMag_d = divisorMagIn;
                partRem_d    = '0;
                count_d      = CNT_W'(WIDTH - 1);
                qNeg_d       = dividendSign ^ divisorSign;
                rNeg_d       = dividendSign;
                ovfPend_d    = bus.is_signed
                               && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                               && (bus.divisor == '1);
            end
        end else if (state_q == RUN) begin
            quot_d    = quotNext;
            partRem_d = remNext;
            count_d   = count_q - 1'b1;
            if (lastIter) begin
                quotOut_d = qNeg_q ? (~quotNext + 1'b1) : quotNext;
                remOut_d  = rNeg_q ? (~remNext + 1'b1)  : remNext;
                divZero_d = 1'b0;
                ovf_d     = ovfPend_q;
            end
        end
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            quot_q       <= '0;
            partRem_q    <= '0;
            divisorMag_q <= '0;
            quotOut_q    <= '0;
            remOut_q     <= '0;
            count_q      <= '0;
            qNeg_q       <= 1'b0;
            rNeg_q       <= 1'b0;
            ovfPend_q    <= 1'b0;
            divZero_q    <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            quot_q       <= quot_d;
            partRem_q    <= partRem_d;
            divisorMag_q <= divisorMag_d;
            quotOut_q    <= quotOut_d;
            remOut_q     <= remOut_d;
            count_q      <= count_d;
            qNeg_q       <= qNeg_d;
            rNeg_q       <= rNeg_d;
            ovfPend_q    <= ovfPend_d;
            divZero_q    <= divZero_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.quotient    = quotOut_q;
    assign bus.remainder   = remOut_q;
    assign bus.div_by_zero = divZero_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed corner cases plus random
// operands checked against a plain-arithmetic division model.
module tb_div_sequencer;
    localparam int WIDTH = 32;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cycleCnt = 0;
    int   compareCount = 0;
    int   mismatchCount = 0;

    div_sequencer_if #(.WIDTH(WIDTH)) bus ();

    div_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Edge counter used to measure latencies
    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference: truncating division done with 64-bit integer arithmetic
    task automatic refModel(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                            output logic dz, output logic ov);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        dz = 1'b0;
        ov = 1'b0;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = WIDTH'(sa / sb);
            r  = WIDTH'(sa % sb);
            ov = (a == MIN_VAL) && (b == '1);
        end else begin
            ua = longint'({32'd0, a});
            ub = longint'({32'd0, b});
            q  = WIDTH'(ua / ub);
            r  = WIDTH'(ua % ub);
        end
    endtask

    task automatic waitReady();
        for (int i = 0; i < 100; i++) begin
            if (bus.ready) break;
            step();
        end
    endtask

    // Drives one start pulse; returns the edge count of the accepting edge
    task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 output int acceptAt);
        waitReady();
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
        step();
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        acceptAt     = cycleCnt;
    endtask

    task automatic waitDone(input string tag, output int doneAt);
        for (int i = 0; i < 200; i++) begin
            if (bus.done) break;
            step();
        end
        checkOutput({tag, ".doneSeen"}, 64'(bus.done), 64'd1);
        doneAt = cycleCnt;
    endtask

    task automatic checkResult(input string tag, input logic s, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input int acceptAt, input int doneAt);
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic dz;
        logic ov;
        int   expLat;
        refModel(s, a, b, q, r, dz, ov);
        expLat = (b == '0) ? 0 : WIDTH;
        checkOutput({tag, ".quotient"}, 64'(bus.quotient), 64'(q));
        checkOutput({tag, ".remainder"}, 64'(bus.remainder), 64'(r));
        checkOutput({tag, ".divByZero"}, 64'(bus.div_by_zero), 64'(dz));
        checkOutput({tag, ".overflow"}, 64'(bus.overflow), 64'(ov));
        checkOutput({tag, ".latency"}, 64'(doneAt - acceptAt), 64'(expLat));
    endtask

    task automatic runOp(input string tag, input logic s, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, output int doneAt);
        int acceptAt;
        applyStimulus(s, a, b, acceptAt);
        waitDone(tag, doneAt);
        checkResult(tag, s, a, b, acceptAt, doneAt);
    endtask

    initial begin
        int acceptAt;
        int doneAt;
        int doneAt2;
        int doneHits;
        logic s;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic dz;
        logic ov;

        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        $display("[TB] starting div_sequencer bench");

        // Reset state
        step();
        step();
        reset = 1'b0;
        checkOutput("reset.ready", 64'(bus.ready), 64'd1);
        checkOutput("reset.busy", 64'(bus.busy), 64'd0);
        checkOutput("reset.done", 64'(bus.done), 64'd0);
        checkOutput("reset.quotient", 64'(bus.quotient), 64'd0);
        checkOutput("reset.remainder", 64'(bus.remainder), 64'd0);

        // Directed cases
        runOp("unsigned100by7", 1'b0, 32'd100, 32'd7, doneAt);
        step();
        checkOutput("donePulse.doneLow", 64'(bus.done), 64'd0);
        checkOutput("donePulse.readyHigh", 64'(bus.ready), 64'd1);
        runOp("signedNeg100by7", 1'b1, 32'hFFFFFF9C, 32'd7, doneAt);
        runOp("divByZero", 1'b0, 32'h12345678, 32'd0, doneAt);
        runOp("signedOverflow", 1'b1, MIN_VAL, 32'hFFFFFFFF, doneAt);
        runOp("unsignedMinByMax", 1'b0, MIN_VAL, 32'hFFFFFFFF, doneAt);
        runOp("signedNegByNeg", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, doneAt);

        // Start during RUN is ignored; original result and timing stand
        applyStimulus(1'b0, 32'd1000, 32'd33, acceptAt);
        repeat (5) step();
        checkOutput("midRun.busy", 64'(bus.busy), 64'd1);
        checkOutput("midRun.readyLow", 64'(bus.ready), 64'd0);
        bus.start    = 1'b1;
        bus.dividend = 32'd999;
        bus.divisor  = 32'd3;
        step();
        bus.start = 1'b0;
        waitDone("ignoredStart", doneAt);
        checkResult("ignoredStart", 1'b0, 32'd1000, 32'd33, acceptAt, doneAt);

        // Back-to-back: start in the first ready cycle after done
        step();
        checkOutput("backToBack.ready", 64'(bus.ready), 64'd1);
        applyStimulus(1'b1, 32'hFFFF0000, 32'd12345, acceptAt);
        repeat (3) step();
        checkOutput("backToBack.holdQuotient", 64'(bus.quotient), 64'(32'd30));
        checkOutput("backToBack.holdRemainder", 64'(bus.remainder), 64'(32'd10));
        waitDone("backToBack", doneAt2);
        checkResult("backToBack", 1'b1, 32'hFFFF0000, 32'd12345, acceptAt, doneAt2);
        checkOutput("backToBack.spacing", 64'(doneAt2 - doneAt), 64'(WIDTH + 2));

        // Reset during iteration 10 clears everything and drops the operation
        applyStimulus(1'b0, 32'hFFFF1234, 32'd3, acceptAt);
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("midReset.ready", 64'(bus.ready), 64'd1);
        checkOutput("midReset.busy", 64'(bus.busy), 64'd0);
        checkOutput("midReset.quotient", 64'(bus.quotient), 64'd0);
        checkOutput("midReset.remainder", 64'(bus.remainder), 64'd0);
        checkOutput("midReset.flags", 64'({bus.div_by_zero, bus.overflow}), 64'd0);
        doneHits = 0;
        repeat (WIDTH + 4) begin
            if (bus.done) doneHits++;
            step();
        end
        checkOutput("midReset.noDone", 64'(doneHits), 64'd0);
        runOp("afterReset", 1'b0, 32'hFFFFFFFF, 32'h10, doneAt);
        refModel(1'b0, 32'hFFFFFFFF, 32'h10, q, r, dz, ov);
        checkOutput("afterReset.modelQuotient", 64'(q), 64'(32'h0FFFFFFF));

        // Randomized operands with a bias toward boundary divisors
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = WIDTH'($urandom_range(1, 15));
                2: b = $urandom;
                3: begin
                    a = MIN_VAL;
                    b = '1;
                end
                4: b = $urandom >> $urandom_range(0, 31);
                default: b = {1'b1, 31'($urandom)};
            endcase
            runOp($sformatf("rand%0d", i), s, a, b, doneAt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
